gpio_port: RTL and testbench

GPIO_PORT -- requirements
Module: gpio_port

---
 rtl/gpio_port.sv | 129 ++++++++++++
 tb/tb_gpio_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
// GPIO port: register-mapped pad outputs, synchronised pad inputs, an
// add/count/toggle output generator and a rising-edge interrupt block.
module gpio_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       bus_addr,
  input  logic [WIDTH-1:0] bus_wdata,
  input  logic             bus_we,
  input  logic             bus_re,
  output logic [WIDTH-1:0] bus_rdata,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_OUT    = 3'd0;
  localparam logic [2:0] ADDR_OE     = 3'd1;
  localparam logic [2:0] ADDR_IN     = 3'd2;
  localparam logic [2:0] ADDR_MODE   = 3'd3;
  localparam logic [2:0] ADDR_EDGE   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_CNT    = 3'd6;

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_ADD    = 2'd1;
  localparam logic [1:0] MODE_COUNT  = 2'd2;
  localparam logic [1:0] MODE_TOGGLE = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_p;
  logic [WIDTH-1:0] in_val, in_prev;
  logic [WIDTH-1:0] out_reg, oe_reg, edge_en, status, cnt, pout;
  logic [1:0]       mode;

  logic [WIDTH-1:0] out_next, oe_next, edge_en_next, status_next, cnt_next, pout_next;
  logic [WIDTH-1:0] rise, clr_mask, rd_sel;
  logic [1:0]       mode_next;

  function automatic logic [WIDTH-1:0] add_wrap(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  function automatic logic [WIDTH-1:0] mode_readback(input logic [1:0] m);
    logic [WIDTH-1:0] r;
    r      = '0;
    r[1:0] = m;
    return r;
  endfunction

  assign in_val = sync_p[SYNC_STAGES-1];
  assign pad_oe = oe_reg;
  assign pad_out = pout;
  assign irq    = |status;

  // Stage p0..pN: pad input synchroniser, last stage is the IN register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p  <= '0;
      in_prev <= '0;
    end else begin
      sync_p[0] <= pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      in_prev <= in_val;
    end
  end

  always_comb begin
    out_next     = (bus_we && bus_addr == ADDR_OUT)  ? bus_wdata      : out_reg;
    oe_next      = (bus_we && bus_addr == ADDR_OE)   ? bus_wdata      : oe_reg;
    mode_next    = (bus_we && bus_addr == ADDR_MODE) ? bus_wdata[1:0] : mode;
    edge_en_next = (bus_we && bus_addr == ADDR_EDGE) ? bus_wdata      : edge_en;
    clr_mask     = (bus_we && bus_addr == ADDR_STATUS) ? bus_wdata    : '0;
    // A fresh edge is OR'ed in after the clear, so set beats W1C
    rise         = in_val & ~in_prev & edge_en;
    status_next  = (status & ~clr_mask) | rise;
    if (bus_we && bus_addr == ADDR_CNT) cnt_next = bus_wdata;
    else if (mode == MODE_COUNT)        cnt_next = add_wrap(cnt, WIDTH'(1));
    else                                cnt_next = cnt;
    case (mode)
      MODE_DIRECT: pout_next = out_next;
      MODE_ADD:    pout_next = add_wrap(in_a, in_val);
      MODE_COUNT:  pout_next = cnt_next;
      MODE_TOGGLE: pout_next = pout ^ out_reg;
      default:     pout_next = pout;
    endcase
  end

  always_comb begin
    case (bus_addr)
      ADDR_OUT:    rd_sel = out_reg;
      ADDR_OE:     rd_sel = oe_reg;
      ADDR_IN:     rd_sel = in_val;
      ADDR_MODE:   rd_sel = mode_readback(mode);
      ADDR_EDGE:   rd_sel = edge_en;
      ADDR_STATUS: rd_sel = status;
      ADDR_CNT:    rd_sel = cnt;
      default:     rd_sel = '0;
    endcase
  end

  // Register stage: bus-visible state, output generator and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg   <= '0;
      oe_reg    <= '0;
      mode      <= MODE_DIRECT;
      edge_en   <= '0;
      status    <= '0;
      cnt       <= '0;
      pout      <= '0;
      bus_rdata <= '0;
    end else begin
      out_reg <= out_next;
      oe_reg  <= oe_next;
      mode    <= mode_next;
      edge_en <= edge_en_next;
      status  <= status_next;
      cnt     <= cnt_next;
      pout    <= pout_next;
      if (bus_re) bus_rdata <= rd_sel;
    end
  end

endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural register-map model.
module tb_gpio_port;
  localparam int W  = 8;
  localparam int SS = 2;

  logic         clk = 0;
  logic         rst;
  logic [2:0]   bus_addr;
  logic [W-1:0] bus_wdata, bus_rdata, in_a, pad_in, pad_out, pad_oe;
  logic         bus_we, bus_re, irq;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  gpio_port #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .in_a(in_a),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oe(pad_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register map values plus the pad_in history queue
  logic [W-1:0] m_out = 0, m_oe = 0, m_een = 0, m_status = 0, m_cnt = 0;
  logic [W-1:0] m_pout = 0, m_rdata = 0, m_prev = 0;
  logic [1:0]   m_mode = 0;
  logic [W-1:0] pq[$];

  function automatic logic [W-1:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return m_out;
      3'd1: return m_oe;
      3'd2: return pq[0];
      3'd3: return {6'b0, m_mode};
      3'd4: return m_een;
      3'd5: return m_status;
      3'd6: return m_cnt;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] in_cur, rise, clr, n_out, n_cnt, n_pout;
    if (rst) begin
      m_out = 0; m_oe = 0; m_een = 0; m_status = 0; m_cnt = 0;
      m_pout = 0; m_rdata = 0; m_prev = 0; m_mode = 0;
      pq.delete();
      for (int i = 0; i < SS; i++) pq.push_back('0);
    end else begin
      in_cur = pq[0];
      if (bus_re) m_rdata = model_read(bus_addr);
      rise   = in_cur & ~m_prev & m_een;
      m_prev = in_cur;
      clr    = (bus_we && bus_addr == 3'd5) ? bus_wdata : '0;
      n_out  = (bus_we && bus_addr == 3'd0) ? bus_wdata : m_out;
      if (bus_we && bus_addr == 3'd6) n_cnt = bus_wdata;
      else if (m_mode == 2)           n_cnt = W'((int'(m_cnt) + 1) % 256);
      else                            n_cnt = m_cnt;
      case (m_mode)
        2'd0: n_pout = n_out;
        2'd1: n_pout = W'((int'(in_a) + int'(in_cur)) % 256);
        2'd2: n_pout = n_cnt;
        default: n_pout = m_pout ^ m_out;
      endcase
      m_status = (m_status & ~clr) | rise;
      if (bus_we && bus_addr == 3'd1) m_oe   = bus_wdata;
      if (bus_we && bus_addr == 3'd3) m_mode = bus_wdata[1:0];
      if (bus_we && bus_addr == 3'd4) m_een  = bus_wdata;
      m_out  = n_out;
      m_cnt  = n_cnt;
      m_pout = n_pout;
      pq.push_back(pad_in);
      void'(pq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pad_out", pad_out, m_pout);
      check("pad_oe", pad_oe, m_oe);
      check("irq", irq, |m_status);
      check("bus_rdata", bus_rdata, m_rdata);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1;
    step();
    bus_we = 0;
  endtask

  task automatic rd(input logic [2:0] a);
    bus_addr = a; bus_re = 1;
    step();
    bus_re = 0;
  endtask

  initial begin
    rst = 1; bus_addr = 0; bus_wdata = 0; bus_we = 0; bus_re = 0;
    in_a = 0; pad_in = 0;
    step(3);
    rst = 0;
    chk_en = 1;

    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check("reset_read", bus_rdata, 8'h00);
    end
    check("reset_oe", pad_oe, 8'h00);
    check("reset_irq", irq, 1'b0);

    // ADD mode: 0xF0 + 0x20 wraps to 0x10
    wr(3'd3, 8'h01);
    in_a = 8'hF0; pad_in = 8'h20;
    step(SS + 1);
    check("add_wrap", pad_out, 8'h10);
    check("add_wrap_model", m_pout, 8'h10);

    // COUNT mode wraps through all-ones
    wr(3'd3, 8'h02);
    wr(3'd6, 8'hFE);
    check("cnt_0", pad_out, 8'hFE);
    step(); check("cnt_1", pad_out, 8'hFF);
    step(); check("cnt_2", pad_out, 8'h00);
    check("cnt_2_model", m_pout, 8'h00);
    step(); check("cnt_3", pad_out, 8'h01);

    // Edge interrupt on bit 0, then W1C
    wr(3'd3, 8'h00);
    wr(3'd4, 8'h01);
    pad_in = 8'h21;
    step(SS + 1);
    check("edge_irq", irq, 1'b1);
    rd(3'd5);
    check("edge_status", bus_rdata, 8'h01);
    wr(3'd5, 8'h01);
    check("w1c_irq", irq, 1'b0);

    // New edge in the same cycle as W1C of that bit: set wins
    pad_in = 8'h20; step(SS + 1);
    pad_in = 8'h21; step(SS + 1);
    check("pre_collide_irq", irq, 1'b1);
    pad_in = 8'h20; step(SS + 1);
    pad_in = 8'h21; step(SS);
    wr(3'd5, 8'h01);
    check("collide_irq", irq, 1'b1);
    rd(3'd5);
    check("collide_status", bus_rdata, 8'h01);
    wr(3'd5, 8'hFF);
    check("clear_all_irq", irq, 1'b0);

    wr(3'd1, 8'hA5);
    check("oe_comb", pad_oe, 8'hA5);

    // Read and write of the same address in one cycle returns the old value
    wr(3'd0, 8'h0F);
    bus_addr = 3'd0; bus_wdata = 8'h33; bus_we = 1; bus_re = 1;
    step();
    bus_we = 0; bus_re = 0;
    check("rw_old", bus_rdata, 8'h0F);
    rd(3'd0);
    check("rw_new", bus_rdata, 8'h33);

    wr(3'd7, 8'hFF);
    rd(3'd7);
    check("reserved", bus_rdata, 8'h00);

    // TOGGLE mode and reset mid-sequence
    rst = 1; step(); rst = 0;
    check("rst_oe", pad_oe, 8'h00);
    check("rst_irq", irq, 1'b0);
    wr(3'd3, 8'h03);
    wr(3'd0, 8'h0F);
    check("tog_start", pad_out, 8'h00);
    step(); check("tog_1", pad_out, 8'h0F);
    step(); check("tog_2", pad_out, 8'h00);
    step(); check("tog_3", pad_out, 8'h0F);
    rst = 1; step(); rst = 0;
    check("tog_rst", pad_out, 8'h00);
    rd(3'd3);
    check("tog_rst_mode", bus_rdata, 8'h00);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      bus_we    = ($urandom_range(0, 2) == 0);
      bus_re    = $urandom_range(0, 1);
      bus_addr  = 3'($urandom_range(0, 7));
      bus_wdata = 8'($urandom);
      in_a      = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pad_in = 8'($urandom);
      step();
    end
    rst = 0; bus_we = 0; bus_re = 0;
    step(2);
    chk_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end
endmodule
